// File: rtl/alu_decode_stage.sv
// RV32I decode stage for the 6-bit-opcode ALU: one-entry registered pipeline stage.
// One cycle latency. in_ready = !out_valid || out_ready. Flush drops the held entry and the input.
module alu_decode_stage #(
  parameter int         PC_W         = 32,
  parameter logic [5:0] ILLEGAL_CODE = 6'h3F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      alu_cntrl,
  output logic [31:0]     imm_val,
  output logic [3:0]      shift_amount,
  output logic            shamt_sel,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal_instr
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  d_alu;
  logic [31:0] d_imm;
  logic [3:0]  d_shamt;
  logic        d_shamt_sel;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_illegal;
  logic        d_we;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    d_alu       = ILLEGAL_CODE;
    d_illegal   = 1'b1;
    d_imm       = '0;
    d_shamt     = '0;
    d_shamt_sel = 1'b0;
    d_rs1       = instr[19:15];
    d_rs2       = instr[24:20];
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00) begin
          d_illegal = 1'b0;
          case (funct3)
            3'b000:  d_alu = 6'd0;
            3'b001:  d_alu = 6'd2;
            3'b010:  d_alu = 6'd3;
            3'b011:  d_alu = 6'd4;
            3'b100:  d_alu = 6'd5;
            3'b101:  d_alu = 6'd6;
            3'b110:  d_alu = 6'd8;
            default: d_alu = 6'd9;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          d_illegal = 1'b0;
          d_alu     = 6'd1;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          d_illegal = 1'b0;
          d_alu     = 6'd7;
        end
      end
      OPC_OP_IMM: begin
        d_rs2 = '0;
        d_imm = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000:  begin d_illegal = 1'b0; d_alu = 6'd10; end
          3'b010:  begin d_illegal = 1'b0; d_alu = 6'd11; end
          3'b011:  begin d_illegal = 1'b0; d_alu = 6'd13; end
          3'b100:  begin d_illegal = 1'b0; d_alu = 6'd14; end
          3'b110:  begin d_illegal = 1'b0; d_alu = 6'd15; end
          3'b111:  begin d_illegal = 1'b0; d_alu = 6'd16; end
          // Only a 4-bit shifter downstream: shamt >= 16 cannot be executed.
          3'b001: begin
            if (funct7 == 7'h00 && !instr[24]) begin
              d_illegal   = 1'b0;
              d_alu       = 6'd12;
              d_shamt     = instr[23:20];
              d_shamt_sel = 1'b1;
            end
          end
          default: begin
            if ((funct7 == 7'h00 || funct7 == 7'h20) && !instr[24]) begin
              d_illegal   = 1'b0;
              d_alu       = (funct7 == 7'h20) ? 6'd7 : 6'd6;
              d_shamt     = instr[23:20];
              d_shamt_sel = 1'b1;
            end
          end
        endcase
      end
      OPC_LUI: begin
        d_illegal = 1'b0;
        d_alu     = 6'd17;
        d_rs1     = '0;
        d_rs2     = '0;
        d_imm     = {instr[31:12], 12'b0};
      end
      default: ;
    endcase
    d_we = !d_illegal && (instr[11:7] != 5'd0);
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      alu_cntrl     <= ILLEGAL_CODE;
      imm_val       <= '0;
      shift_amount  <= '0;
      shamt_sel     <= 1'b0;
      rs1_addr      <= '0;
      rs2_addr      <= '0;
      rd_addr       <= '0;
      rd_we         <= 1'b0;
      illegal_instr <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      alu_cntrl     <= d_alu;
      imm_val       <= d_imm;
      shift_amount  <= d_shamt;
      shamt_sel     <= d_shamt_sel;
      rs1_addr      <= d_rs1;
      rs2_addr      <= d_rs2;
      rd_addr       <= instr[11:7];
      rd_we         <= d_we;
      illegal_instr <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vector table, handshake corner sequences, random vs. model.
module tb_alu_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, in_pc, out_pc, imm_val;
  logic [5:0]  alu_cntrl;
  logic [3:0]  shift_amount;
  logic        shamt_sel, rd_we, illegal_instr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  always #5 clk = ~clk;

  alu_decode_stage #(.PC_W(32), .ILLEGAL_CODE(6'h3F)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_cntrl(alu_cntrl), .imm_val(imm_val), .shift_amount(shift_amount),
    .shamt_sel(shamt_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_we(rd_we), .illegal_instr(illegal_instr)
  );

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [3:0]  sh;
    logic        ss;
    logic        ill;
    logic        we;
  } vec_t;

  typedef struct packed {
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [3:0]  sh;
    logic        ss;
    logic        ill;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  int total = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode from the instruction-set rules, table-lookup style.
  function automatic exp_t ref_decode(logic [31:0] i);
    exp_t e;
    int rtab [8];
    int itab [8];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    rtab = '{0, 2, 3, 4, 5, 6, 8, 9};
    itab = '{10, 12, 11, 13, 14, 6, 15, 16};
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e = '0;
    e.alu = 6'h3F; e.ill = 1'b1;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin e.alu = 6'(rtab[f3]); e.ill = 1'b0; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin e.alu = 6'd1; e.ill = 1'b0; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin e.alu = 6'd7; e.ill = 1'b0; end
    end else if (op == 7'h13) begin
      e.rs2 = 5'd0;
      e.imm = 32'(signed'(i[31:20]));
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (!i[24] && (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20))) begin
          e.ill = 1'b0;
          e.alu = (f7 == 7'h20) ? 6'd7 : 6'(itab[f3]);
          e.ss = 1'b1;
          e.sh = i[23:20];
        end
      end else begin
        e.ill = 1'b0;
        e.alu = 6'(itab[f3]);
      end
    end else if (op == 7'h37) begin
      e.ill = 1'b0; e.alu = 6'd17; e.rs1 = 5'd0; e.rs2 = 5'd0;
      e.imm = {i[31:12], 12'h000};
    end
    e.we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic chk_out(string tag, exp_t e);
    chk({tag, " alu_cntrl"}, 32'(alu_cntrl), 32'(e.alu));
    chk({tag, " illegal"}, 32'(illegal_instr), 32'(e.ill));
    chk({tag, " rd_we"}, 32'(rd_we), 32'(e.we));
    chk({tag, " rd"}, 32'(rd_addr), 32'(e.rd));
    chk({tag, " rs1"}, 32'(rs1_addr), 32'(e.rs1));
    if (!e.ill) begin
      chk({tag, " imm"}, imm_val, e.imm);
      chk({tag, " shamt"}, 32'(shift_amount), 32'(e.sh));
      chk({tag, " shamt_sel"}, 32'(shamt_sel), 32'(e.ss));
      chk({tag, " rs2"}, 32'(rs2_addr), 32'(e.rs2));
    end
  endtask

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 2))
      0: return 7'h00;
      1: return 7'h20;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: begin w[6:0] = 7'h13; w[31:25] = pick_f7(); end
      default: ;
    endcase
    return w;
  endfunction

  vec_t tbl [13];
  logic  mfull;
  exp_t  ment;
  logic [31:0] mpc;

  initial begin
    tbl[0]  = '{32'h002081B3, 6'd0,  32'h00000000, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[1]  = '{32'hFFF00293, 6'd10, 32'hFFFFFFFF, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[2]  = '{32'h123453B7, 6'd17, 32'h12345000, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[3]  = '{32'h40325213, 6'd7,  32'h00000403, 4'd3,  1'b1, 1'b0, 1'b1};
    tbl[4]  = '{32'h01009093, 6'h3F, 32'h00000000, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'h403100B3, 6'd1,  32'h00000000, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[6]  = '{32'h00208033, 6'd0,  32'h00000000, 4'd0,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000006F, 6'h3F, 32'h00000000, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[8]  = '{32'h00208030, 6'h3F, 32'h00000000, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[9]  = '{32'h0041D133, 6'd6,  32'h00000000, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[10] = '{32'h0050B313, 6'd13, 32'h00000005, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[11] = '{32'h00F09093, 6'd12, 32'h0000000F, 4'd15, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{32'h02208033, 6'h3F, 32'h00000000, 4'd0,  1'b0, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; in_pc = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset alu_cntrl", 32'(alu_cntrl), 32'h3F);
    chk("reset imm", imm_val, 32'd0);
    chk("reset rd_we", 32'(rd_we), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Directed vector table, one instruction per cycle.
    for (int k = 0; k < 13; k++) begin
      step();
      in_valid = 1'b1; instr = tbl[k].instr; in_pc = 32'(k * 4); out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d out_pc", k), out_pc, 32'(k * 4));
      chk($sformatf("vec%0d alu_cntrl", k), 32'(alu_cntrl), 32'(tbl[k].alu));
      chk($sformatf("vec%0d illegal", k), 32'(illegal_instr), 32'(tbl[k].ill));
      chk($sformatf("vec%0d rd_we", k), 32'(rd_we), 32'(tbl[k].we));
      chk($sformatf("vec%0d rd", k), 32'(rd_addr), 32'(tbl[k].instr[11:7]));
      if (!tbl[k].ill) begin
        chk($sformatf("vec%0d imm", k), imm_val, tbl[k].imm);
        chk($sformatf("vec%0d shamt", k), 32'(shift_amount), 32'(tbl[k].sh));
        chk($sformatf("vec%0d shamt_sel", k), 32'(shamt_sel), 32'(tbl[k].ss));
      end
    end
    step();
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // Stall: held entry frozen for 5 cycles, pending input neither lost nor duplicated.
    in_valid = 1'b1; instr = 32'h002081B3; in_pc = 32'd100; out_ready = 1'b0;
    step();
    instr = 32'hFFF00293; in_pc = 32'd104;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall out_pc", out_pc, 32'd100);
      chk("stall alu_cntrl", 32'(alu_cntrl), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("after stall out_valid", 32'(out_valid), 32'd1);
    chk("after stall out_pc", out_pc, 32'd104);
    chk("after stall alu_cntrl", 32'(alu_cntrl), 32'd10);
    step();
    chk("after stall drained", 32'(out_valid), 32'd0);

    // Back-to-back stream of 8 instructions at full throughput.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      instr = {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13};
      in_pc = 32'(200 + 4 * k);
      step();
      chk($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d out_pc", k), out_pc, 32'(200 + 4 * k));
      chk($sformatf("stream%0d rd", k), 32'(rd_addr), 32'(k + 1));
    end
    in_valid = 1'b0;
    step();
    chk("stream end out_valid", 32'(out_valid), 32'd0);

    // Flush with full stage and a new input offered.
    in_valid = 1'b1; instr = 32'h002081B3; in_pc = 32'd300; out_ready = 1'b0;
    step();
    instr = 32'h123453B7; in_pc = 32'd304; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    chk("flush nothing emitted", 32'(out_valid), 32'd0);

    // Reset mid-stream overrides pending input.
    in_valid = 1'b1; instr = 32'h40325213; in_pc = 32'd400; out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst alu_cntrl", 32'(alu_cntrl), 32'h3F);
    chk("midrst imm", imm_val, 32'd0);
    chk("midrst shamt_sel", 32'(shamt_sel), 32'd0);
    chk("midrst out_pc", out_pc, 32'd0);
    chk("midrst rd", 32'(rd_addr), 32'd0);

    // Random traffic against a one-entry model.
    mfull = 1'b0; ment = '0; mpc = '0;
    step();
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      instr     = rand_instr();
      in_pc     = $urandom;
      #1;
      chk("rand out_valid", 32'(out_valid), 32'(mfull));
      chk("rand in_ready", 32'(in_ready), 32'(!mfull || out_ready));
      if (mfull && out_ready) begin
        chk("rand out_pc", out_pc, mpc);
        chk_out("rand", ment);
      end
      if (flush) mfull = 1'b0;
      else if (in_valid && (!mfull || out_ready)) begin
        ment = ref_decode(instr); mpc = in_pc; mfull = 1'b1;
      end else if (out_ready) mfull = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
